// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stage enables, bubble insertion,
// multi-cycle EX sequencing and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter bit FWD_EN   = 1'b0,
  parameter int BR_STAGE = 1,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_IDEX,
  input  logic              MemRead_IDEX,
  input  logic [ADDR_W-1:0] Rd_IDEX,
  input  logic              RegWrite_EXMem,
  input  logic [ADDR_W-1:0] Rd_EXMem,
  input  logic [ADDR_W-1:0] Rs1_ID,
  input  logic [ADDR_W-1:0] Rs2_ID,
  input  logic              Rs1_used,
  input  logic              Rs2_used,
  input  logic              redirect,
  input  logic              mem_busy,
  input  logic              md_op_EX,
  input  logic              md_done,
  input  logic              perf_clr,
  output logic              en_IF,
  output logic              en_IFID,
  output logic              en_IDEX,
  output logic              en_EXMem,
  output logic              en_MemWB,
  output logic              NOP_IFID,
  output logic              NOP_IDEX,
  output logic              NOP_EXMem,
  output logic              md_go,
  output logic              md_kill,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  // DONE holds a result that arrived while memory froze the pipe, so no second start is issued.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   hz_idex, hz_exmem, data_stall;
  logic   md_start, md_wait, flush_hit;

  function automatic logic src_match(input logic [ADDR_W-1:0] rd,
                                     input logic [ADDR_W-1:0] rs,
                                     input logic              used);
    return used && (rs != '0) && (rd == rs);
  endfunction

  always_comb begin
    hz_idex  = src_match(Rd_IDEX, Rs1_ID, Rs1_used) || src_match(Rd_IDEX, Rs2_ID, Rs2_used);
    hz_exmem = src_match(Rd_EXMem, Rs1_ID, Rs1_used) || src_match(Rd_EXMem, Rs2_ID, Rs2_used);
    if (FWD_EN)
      data_stall = MemRead_IDEX && RegWrite_IDEX && hz_idex;
    else
      data_stall = (RegWrite_IDEX && hz_idex) || (RegWrite_EXMem && hz_exmem);
    md_start = (state == IDLE) && md_op_EX && !md_done && !redirect && !mem_busy;
    md_wait  = ((state == BUSY) && !md_done) || md_start;
  end

  always_comb begin
    en_IF     = 1'b1;
    en_IFID   = 1'b1;
    en_IDEX   = 1'b1;
    en_EXMem  = 1'b1;
    en_MemWB  = 1'b1;
    NOP_IFID  = 1'b0;
    NOP_IDEX  = 1'b0;
    NOP_EXMem = 1'b0;
    md_go     = 1'b0;
    md_kill   = 1'b0;
    flush_hit = 1'b0;
    if (!rst_n) begin
      en_IF     = 1'b0;
      en_IFID   = 1'b0;
      en_IDEX   = 1'b0;
      en_EXMem  = 1'b0;
      en_MemWB  = 1'b0;
      NOP_IFID  = 1'b1;
      NOP_IDEX  = 1'b1;
      NOP_EXMem = 1'b1;
    end else if (mem_busy) begin
      en_IF    = 1'b0;
      en_IFID  = 1'b0;
      en_IDEX  = 1'b0;
      en_EXMem = 1'b0;
      en_MemWB = 1'b0;
    end else if (redirect) begin
      // A redirect seen while BUSY means the md op itself is wrong-path: kill it and flush EX/Mem too.
      flush_hit = 1'b1;
      NOP_IFID  = 1'b1;
      NOP_IDEX  = 1'b1;
      NOP_EXMem = (BR_STAGE == 2) || (state == BUSY);
      md_kill   = (state == BUSY);
    end else if (md_wait) begin
      en_IF     = 1'b0;
      en_IFID   = 1'b0;
      en_IDEX   = 1'b0;
      NOP_EXMem = 1'b1;
      md_go     = (state == IDLE);
    end else if (data_stall) begin
      en_IF    = 1'b0;
      en_IFID  = 1'b0;
      NOP_IDEX = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (md_start) state <= BUSY;
        BUSY: begin
          if (md_done)
            state <= mem_busy ? DONE : IDLE;
          else if (!mem_busy && redirect)
            state <= IDLE;
        end
        DONE: if (!mem_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!en_IF && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_hit && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two configurations share stimulus and are checked
// every cycle against a rule-level reference model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       rw_idex;
    logic       mr_idex;
    logic [4:0] rd_idex;
    logic       rw_exmem;
    logic [4:0] rd_exmem;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       redirect;
    logic       mem_busy;
    logic       md_op;
    logic       md_done;
    logic       perf_clr;
  } stim_t;

  typedef struct {
    logic [9:0]  ca;
    logic [9:0]  cb;
    logic [31:0] na;
    logic [31:0] nb;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rw_idex, mr_idex, rw_exmem, u1, u2, redirect, mem_busy, md_op, md_done, perf_clr;
  logic [4:0] rd_idex, rd_exmem, rs1, rs2;

  logic en_if_a, en_ifid_a, en_idex_a, en_exmem_a, en_memwb_a, nop_ifid_a, nop_idex_a, nop_exmem_a, go_a, kill_a;
  logic en_if_b, en_ifid_b, en_idex_b, en_exmem_b, en_memwb_b, nop_ifid_b, nop_idex_b, nop_exmem_b, go_b, kill_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  int    total_cnt = 0;
  int    pass_cnt  = 0;
  exp_t  sb[$];
  string phase = "reset";

  bit fwd [2] = '{1'b0, 1'b1};
  int br  [2] = '{1, 2};
  int cmax[2] = '{65535, 15};
  bit m_busy[2];
  bit m_pend[2];
  int m_stall[2];
  int m_flush[2];

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1'b0), .BR_STAGE(1), .ADDR_W(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_IDEX(rw_idex), .MemRead_IDEX(mr_idex), .Rd_IDEX(rd_idex),
    .RegWrite_EXMem(rw_exmem), .Rd_EXMem(rd_exmem),
    .Rs1_ID(rs1), .Rs2_ID(rs2), .Rs1_used(u1), .Rs2_used(u2),
    .redirect(redirect), .mem_busy(mem_busy), .md_op_EX(md_op), .md_done(md_done), .perf_clr(perf_clr),
    .en_IF(en_if_a), .en_IFID(en_ifid_a), .en_IDEX(en_idex_a), .en_EXMem(en_exmem_a), .en_MemWB(en_memwb_a),
    .NOP_IFID(nop_ifid_a), .NOP_IDEX(nop_idex_a), .NOP_EXMem(nop_exmem_a),
    .md_go(go_a), .md_kill(kill_a), .stall_cycles(stall_a), .flush_events(flush_a)
  );

  hazard_ctrl #(.FWD_EN(1'b1), .BR_STAGE(2), .ADDR_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_IDEX(rw_idex), .MemRead_IDEX(mr_idex), .Rd_IDEX(rd_idex),
    .RegWrite_EXMem(rw_exmem), .Rd_EXMem(rd_exmem),
    .Rs1_ID(rs1), .Rs2_ID(rs2), .Rs1_used(u1), .Rs2_used(u2),
    .redirect(redirect), .mem_busy(mem_busy), .md_op_EX(md_op), .md_done(md_done), .perf_clr(perf_clr),
    .en_IF(en_if_b), .en_IFID(en_ifid_b), .en_IDEX(en_idex_b), .en_EXMem(en_exmem_b), .en_MemWB(en_memwb_b),
    .NOP_IFID(nop_ifid_b), .NOP_IDEX(nop_idex_b), .NOP_EXMem(nop_exmem_b),
    .md_go(go_b), .md_kill(kill_b), .stall_cycles(stall_b), .flush_events(flush_b)
  );

  function automatic bit reads(input stim_t s, input logic [4:0] rd);
    return (s.u1 && s.rs1 != 5'd0 && s.rs1 == rd) || (s.u2 && s.rs2 != 5'd0 && s.rs2 == rd);
  endfunction

  // Reference: a prioritised rule table plus "op in flight" / "result parked" flags.
  task automatic model_step(input int k, input stim_t s, output logic [9:0] ctrl, output logic [31:0] cnt);
    bit data_hz, start, wait_md, flush, go, kill;
    bit [4:0] en;
    bit [2:0] nop;
    if (fwd[k]) data_hz = s.mr_idex && s.rw_idex && reads(s, s.rd_idex);
    else        data_hz = (s.rw_idex && reads(s, s.rd_idex)) || (s.rw_exmem && reads(s, s.rd_exmem));
    cnt = {16'(m_stall[k]), 16'(m_flush[k])};
    en = 5'b11111; nop = 3'b000; go = 0; kill = 0; flush = 0;
    if (!s.rst_n) begin
      en = 5'b00000; nop = 3'b111;
      m_busy[k] = 0; m_pend[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      cnt = 32'd0;
    end else begin
      start   = !m_busy[k] && !m_pend[k] && s.md_op && !s.md_done && !s.redirect && !s.mem_busy;
      wait_md = (m_busy[k] && !s.md_done) || start;
      if (s.mem_busy) en = 5'b00000;
      else if (s.redirect) begin
        flush = 1; kill = m_busy[k];
        nop = (br[k] == 2 || m_busy[k]) ? 3'b111 : 3'b110;
      end else if (wait_md) begin
        en = 5'b00011; nop = 3'b001; go = !m_busy[k];
      end else if (data_hz) begin
        en = 5'b00111; nop = 3'b010;
      end
      if (s.perf_clr) begin
        m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (!en[4] && m_stall[k] < cmax[k]) m_stall[k]++;
        if (flush && m_flush[k] < cmax[k]) m_flush[k]++;
      end
      if (s.mem_busy) begin
        if (m_busy[k] && s.md_done) begin m_busy[k] = 0; m_pend[k] = 1; end
      end else begin
        m_pend[k] = 0;
        if (m_busy[k] && (s.md_done || s.redirect)) m_busy[k] = 0;
        else if (start) m_busy[k] = 1;
      end
    end
    ctrl = {en, nop, go, kill};
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n; rw_idex = s.rw_idex; mr_idex = s.mr_idex; rd_idex = s.rd_idex;
    rw_exmem = s.rw_exmem; rd_exmem = s.rd_exmem; rs1 = s.rs1; rs2 = s.rs2;
    u1 = s.u1; u2 = s.u2; redirect = s.redirect; mem_busy = s.mem_busy;
    md_op = s.md_op; md_done = s.md_done; perf_clr = s.perf_clr;
    model_step(0, s, e.ca, e.na);
    model_step(1, s, e.cb, e.nb);
    e.tag = phase;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t quiet();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents outputs; compare them with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, "/a_ctrl"},
          {22'd0, en_if_a, en_ifid_a, en_idex_a, en_exmem_a, en_memwb_a, nop_ifid_a, nop_idex_a, nop_exmem_a, go_a, kill_a},
          {22'd0, e.ca});
        checkOutput({e.tag, "/a_cnt"}, {stall_a, flush_a}, e.na);
        checkOutput({e.tag, "/b_ctrl"},
          {22'd0, en_if_b, en_ifid_b, en_idex_b, en_exmem_b, en_memwb_b, nop_ifid_b, nop_idex_b, nop_exmem_b, go_b, kill_b},
          {22'd0, e.cb});
        checkOutput({e.tag, "/b_cnt"}, {12'd0, stall_b, 12'd0, flush_b}, e.nb);
      end
    end
  end

  initial begin
    stim_t s;
    rw_idex = 0; mr_idex = 0; rd_idex = 0; rw_exmem = 0; rd_exmem = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; redirect = 0; mem_busy = 0; md_op = 0; md_done = 0; perf_clr = 0;

    s = quiet(); s.rst_n = 1'b0;
    repeat (2) applyStimulus(s);

    phase = "raw";
    s = quiet(); s.rw_idex = 1; s.rd_idex = 5; s.rs1 = 5; s.u1 = 1;
    applyStimulus(s);
    s.rs1 = 0; s.rd_idex = 0;
    applyStimulus(s);
    s = quiet(); s.rw_idex = 1; s.rd_idex = 5; s.rs1 = 5; s.u1 = 1; s.mr_idex = 1;
    applyStimulus(s);
    s = quiet(); s.rw_exmem = 1; s.rd_exmem = 7; s.rs2 = 7; s.u2 = 1;
    applyStimulus(s);
    s.u2 = 0;
    applyStimulus(s);

    phase = "redirect";
    s = quiet(); s.redirect = 1;
    applyStimulus(s);
    s.rw_idex = 1; s.rd_idex = 3; s.rs1 = 3; s.u1 = 1; s.mr_idex = 1;
    applyStimulus(s);

    phase = "md";
    s = quiet(); s.perf_clr = 1;
    applyStimulus(s);
    s = quiet(); s.md_op = 1;
    repeat (4) applyStimulus(s);
    s.md_done = 1;
    applyStimulus(s);
    s = quiet();
    applyStimulus(s);
    #3;
    checkOutput("md_stall_a", {16'd0, stall_a}, 32'd4);
    checkOutput("md_stall_b", {28'd0, stall_b}, 32'd4);

    phase = "md_kill";
    s = quiet(); s.md_op = 1;
    repeat (2) applyStimulus(s);
    s.redirect = 1;
    applyStimulus(s);
    s = quiet();
    applyStimulus(s);

    phase = "md_freeze";
    s = quiet(); s.md_op = 1;
    repeat (2) applyStimulus(s);
    s.mem_busy = 1;
    applyStimulus(s);
    s.md_done = 1;
    applyStimulus(s);
    s.md_done = 0;
    applyStimulus(s);
    s.mem_busy = 0;
    applyStimulus(s);
    s = quiet();
    applyStimulus(s);

    phase = "sat";
    s = quiet(); s.perf_clr = 1;
    applyStimulus(s);
    s = quiet(); s.rw_idex = 1; s.mr_idex = 1; s.rd_idex = 9; s.rs2 = 9; s.u2 = 1;
    repeat (20) applyStimulus(s);
    s = quiet();
    applyStimulus(s);
    #3;
    checkOutput("sat_stall_b", {28'd0, stall_b}, 32'd15);
    checkOutput("sat_stall_a", {16'd0, stall_a}, 32'd20);
    s.perf_clr = 1;
    applyStimulus(s);
    s.perf_clr = 0;
    applyStimulus(s);
    #3;
    checkOutput("clr_stall_b", {28'd0, stall_b}, 32'd0);

    phase = "rst_busy";
    s = quiet(); s.md_op = 1;
    repeat (2) applyStimulus(s);
    s.rst_n = 0;
    applyStimulus(s);
    s = quiet();
    repeat (2) applyStimulus(s);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      s = quiet();
      s.rst_n    = ($urandom_range(0, 99) != 0);
      s.rw_idex  = $urandom_range(0, 1);
      s.mr_idex  = $urandom_range(0, 1);
      s.rd_idex  = 5'($urandom_range(0, 3));
      s.rw_exmem = $urandom_range(0, 1);
      s.rd_exmem = 5'($urandom_range(0, 3));
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.u1       = $urandom_range(0, 1);
      s.u2       = $urandom_range(0, 1);
      s.redirect = ($urandom_range(0, 7) == 0);
      s.mem_busy = ($urandom_range(0, 6) == 0);
      s.md_op    = ($urandom_range(0, 2) == 0);
      s.md_done  = ($urandom_range(0, 4) == 0);
      s.perf_clr = ($urandom_range(0, 40) == 0);
      applyStimulus(s);
    end

    phase = "drain";
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
